// File: rtl/sram_frame_buf_pkg.sv
// Shared types and defaults for the single-frame SRAM store-and-forward buffer.
// Contents:
//   SFB_DATA_W / SFB_DEPTH / SFB_ADDR_W : default word width, depth, address width
//   state_e                             : controller FSM states (IDLE, FILL, DRAIN)
//   bitrev()                            : reverses the low w bits of an address
package sram_frame_buf_pkg;

  localparam int unsigned SFB_DATA_W   = 32;
  localparam int unsigned SFB_DEPTH    = 256;
  localparam int unsigned SFB_ADDR_W   = 8;
  localparam int unsigned BITREV_MAX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Reverse the full BITREV_MAX_W-bit field, then shift the reversed low w
  // bits back down so only the requested width is mirrored.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(
    input logic [BITREV_MAX_W-1:0] a,
    input int unsigned             w
  );
    logic [BITREV_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
      r[i] = a[BITREV_MAX_W-1-i];
    end
    return r >> (BITREV_MAX_W - w);
  endfunction

endpackage

// File: rtl/sram_rd_skid.sv
// Two-entry output skid FIFO for SRAM read data.
// Each entry carries {last, data}. The controller guarantees it never pushes
// into a full FIFO, so no full/overflow handling is done here.
// Ports:
//   clock, reset_n       : clock, synchronous active-low reset
//   push, push_last,
//   push_data            : write one entry
//   pop                  : remove the head entry (ignored when empty)
//   head_last, head_data : current head entry
//   count                : occupancy 0..2
module sram_rd_skid
  import sram_frame_buf_pkg::*;
#(
  parameter int unsigned DATA_W = SFB_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              push_last,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_last,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W:0] ent_q [2];
  logic [DATA_W:0] ent_d [2];
  logic            wr_ptr_q, wr_ptr_d;
  logic            rd_ptr_q, rd_ptr_d;
  logic [1:0]      count_q, count_d;
  logic            pop_eff;

  assign pop_eff = pop && (count_q != 2'd0);

  always_comb begin
    ent_d[0] = ent_q[0];
    ent_d[1] = ent_q[1];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      ent_d[wr_ptr_q] = {push_last, push_data};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_eff) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop_eff})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_last = ent_q[rd_ptr_q][DATA_W];
  assign head_data = ent_q[rd_ptr_q][DATA_W-1:0];
  assign count     = count_q;

endmodule

// File: rtl/sram_frame_buf_ctrl.sv
// Single-frame store-and-forward controller for a 1W/1R SRAM (1-cycle read).
// Fills one frame from the input stream into SRAM, then drains it in order
// to the output stream with full backpressure through a 2-entry skid FIFO.
// Optional build macro SRAM_FRAME_BUF_BITREV_EN: read addresses are the
// bit-reverse of the read counter and the frame length is forced to DEPTH.
// Ports:
//   clock, reset_n                 : clock, synchronous active-low reset
//   frame_len                      : words per frame (0 or >DEPTH -> DEPTH)
//   in_valid/in_ready/in_data      : input stream
//   out_valid/out_ready/out_data,
//   out_last                       : output stream, out_last on final word
//   mem_w_en/mem_w_addr/mem_w_data : SRAM write port
//   mem_r_en/mem_r_addr/mem_r_data : SRAM read port (data next cycle)
//   busy                           : high in FILL or DRAIN
//   frame_done                     : 1-cycle pulse after last beat accepted
module sram_frame_buf_ctrl
  import sram_frame_buf_pkg::*;
#(
  parameter int unsigned DATA_W = SFB_DATA_W,
  parameter int unsigned DEPTH  = SFB_DEPTH,
  parameter int unsigned ADDR_W = SFB_ADDR_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W:0]   frame_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              mem_w_en,
  output logic [ADDR_W-1:0] mem_w_addr,
  output logic [DATA_W-1:0] mem_w_data,
  output logic              mem_r_en,
  output logic [ADDR_W-1:0] mem_r_addr,
  input  logic [DATA_W-1:0] mem_r_data,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wcnt_q, wcnt_d;
  logic [ADDR_W:0] rcnt_q, rcnt_d;
  logic            inflight_q, inflight_d;
  logic            inflight_last_q, inflight_last_d;
  logic            frame_done_q, frame_done_d;

  logic [ADDR_W:0]   len_legal;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        fifo_count;
  logic              head_last;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic [2:0]        occupancy;
  logic [2:0]        occ_limit;

`ifdef SRAM_FRAME_BUF_BITREV_EN
  logic unused_frame_len;
  assign unused_frame_len = ^frame_len;
  assign len_legal        = LEN_MAX;
  assign rd_addr          = ADDR_W'(bitrev(BITREV_MAX_W'(rcnt_q[ADDR_W-1:0]), ADDR_W));
`else
  assign len_legal = ((frame_len == '0) || (frame_len > LEN_MAX)) ? LEN_MAX : frame_len;
  assign rd_addr   = rcnt_q[ADDR_W-1:0];
`endif

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Read gating: FIFO entries plus the read in flight must stay below 2,
  // with a pop this cycle freeing one slot (written as +pop on the limit
  // side to keep the arithmetic unsigned).
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign occ_limit = 3'd2 + {2'b00, pop};

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    wcnt_d          = wcnt_q;
    rcnt_d          = rcnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    frame_done_d    = 1'b0;
    in_ready        = 1'b0;
    mem_w_en        = 1'b0;
    mem_w_addr      = '0;
    mem_w_data      = '0;
    mem_r_en        = 1'b0;
    mem_r_addr      = '0;

    case (state_q)
      IDLE: begin
        state_d = FILL;
        len_d   = len_legal;
        wcnt_d  = '0;
      end
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_w_en   = 1'b1;
          mem_w_addr = wcnt_q[ADDR_W-1:0];
          mem_w_data = in_data;
          wcnt_d     = wcnt_q + CNT_ONE;
          if (wcnt_q == (len_q - CNT_ONE)) begin
            state_d = DRAIN;
            rcnt_d  = '0;
          end
        end
      end
      DRAIN: begin
        if ((rcnt_q < len_q) && (occupancy < occ_limit)) begin
          mem_r_en        = 1'b1;
          mem_r_addr      = rd_addr;
          rcnt_d          = rcnt_q + CNT_ONE;
          inflight_d      = 1'b1;
          inflight_last_d = (rcnt_q == (len_q - CNT_ONE));
        end
        if (pop && head_last) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      len_q           <= '0;
      wcnt_q          <= '0;
      rcnt_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      wcnt_q          <= wcnt_d;
      rcnt_q          <= rcnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Read data returns one cycle after issue and is pushed unconditionally;
  // the issue gating above guarantees a free slot.
  sram_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight_q),
    .push_last (inflight_last_q),
    .push_data (mem_r_data),
    .pop       (pop),
    .head_last (head_last),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign out_data   = out_valid ? head_data : '0;
  assign out_last   = out_valid && head_last;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sram_frame_buf_ctrl.sv
// Scoreboard bench for sram_frame_buf_ctrl with a behavioural 1-cycle SRAM.
module tb_sram_frame_buf_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 256;
  localparam int unsigned AW  = 8;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  logic          clock;
  logic          reset_n;
  logic [AW:0]   frame_len;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          mem_w_en;
  logic [AW-1:0] mem_w_addr;
  logic [DW-1:0] mem_w_data;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_r_data;
  logic          busy;
  logic          frame_done;

  logic [DW-1:0] sram [DEP];
  exp_t          exp_q [$];
  int            checks;
  int            failures;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  sram_frame_buf_ctrl #(
    .DATA_W (DW),
    .DEPTH  (DEP),
    .ADDR_W (AW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .frame_len  (frame_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .mem_w_en   (mem_w_en),
    .mem_w_addr (mem_w_addr),
    .mem_w_data (mem_w_data),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_r_data (mem_r_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always @(posedge clock) begin
    if (mem_w_en) sram[mem_w_addr] <= mem_w_data;
    if (mem_r_en) mem_r_data <= sram[mem_r_addr];
  end

  always @(negedge clock) begin
    if (reset_n) assert (dut.fifo_count <= 2'd2) else $error("skid FIFO overflow");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] tb_bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int unsigned k);
    logic [AW-1:0] a;
    a = k[AW-1:0];
`ifdef SRAM_FRAME_BUF_BITREV_EN
    return tb_bitrev(a);
`else
    return a;
`endif
  endfunction

  function automatic int unsigned legal_len(input int unsigned len_cfg);
`ifdef SRAM_FRAME_BUF_BITREV_EN
    return DEP;
`else
    return ((len_cfg == 0) || (len_cfg > DEP)) ? DEP : len_cfg;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_in_ready"},  in_ready,   0);
    check_eq({tag, "_out_valid"}, out_valid,  0);
    check_eq({tag, "_out_data"},  out_data,   0);
    check_eq({tag, "_out_last"},  out_last,   0);
    check_eq({tag, "_w_en"},      mem_w_en,   0);
    check_eq({tag, "_w_addr"},    mem_w_addr, 0);
    check_eq({tag, "_r_en"},      mem_r_en,   0);
    check_eq({tag, "_r_addr"},    mem_r_addr, 0);
    check_eq({tag, "_busy"},      busy,       0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
  endtask

  // Runs one frame starting in the DUT's IDLE cycle. rdy_mode: 0 always
  // ready, 1 ready every third cycle, 2 random. abort_after>0 stops the
  // frame right after that many output beats were accepted.
  task automatic run_frame(input int unsigned len_cfg, input int unsigned in_pct,
                           input int unsigned rdy_mode, input logic [DW-1:0] base,
                           input int unsigned abort_after, output bit aborted);
    int unsigned   L, wr_idx, rd_cnt, iss_idx, last_acc_cyc, first_pop_cyc, last_pop_cyc;
    bit            seen_val, done_pend, finished;
    logic [DW-1:0] words [DEP];
    exp_t          e;
    L = legal_len(len_cfg);
    exp_q.delete();
    frame_len = len_cfg[AW:0];
    wr_idx = 0; rd_cnt = 0; iss_idx = 0;
    last_acc_cyc = 0; first_pop_cyc = 0; last_pop_cyc = 0;
    seen_val = 0; done_pend = 0; finished = 0; aborted = 0;
    for (int unsigned cyc = 0; cyc < 6 * L + 100 && !finished && !aborted; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < in_pct);
      in_data   = base + wr_idx;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 0) begin
        check_eq("idle_in_ready", in_ready, 0);
        check_eq("idle_busy", busy, 0);
      end else if (wr_idx < L) begin
        check_eq("fill_in_ready", in_ready, 1);
        check_eq("fill_busy", busy, 1);
      end else begin
        check_eq("drain_in_ready", in_ready, 0);
      end
      check_eq("w_en", mem_w_en, in_valid && in_ready);
      if (in_valid && in_ready) begin
        check_eq("w_addr", mem_w_addr, wr_idx[AW-1:0]);
        check_eq("w_data", mem_w_data, in_data);
        words[wr_idx[AW-1:0]] = in_data;
        if (wr_idx == L - 1) begin
          last_acc_cyc = cyc;
          for (int unsigned k = 0; k < L; k++) begin
            e.last = (k == L - 1);
            e.data = words[exp_addr(k)];
            exp_q.push_back(e);
          end
        end
        wr_idx++;
      end
      if (mem_r_en) begin
        check_eq("r_overrun", iss_idx < L, 1);
        check_eq("r_addr", mem_r_addr, exp_addr(iss_idx));
        iss_idx++;
      end
      if (out_valid && !seen_val) begin
        seen_val = 1;
        check_eq("first_valid_latency", cyc - last_acc_cyc, 3);
      end
      check_eq("fifo_le2", dut.fifo_count <= 2'd2, 1);
      if (cyc > 0) check_eq("frame_done", frame_done, done_pend);
      if (done_pend) finished = 1;
      done_pend = 0;
      if (out_valid && out_ready) begin
        check_eq("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_data", out_data, e.data);
          check_eq("out_last", out_last, e.last);
          done_pend = e.last;
        end
        if (rd_cnt == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        rd_cnt++;
        if (abort_after != 0 && rd_cnt == abort_after) aborted = 1;
      end
      if (!finished && !aborted) begin
        @(posedge clock);
        #1;
      end
    end
    check_eq("frame_complete", finished || aborted, 1);
    if (finished) begin
      check_eq("beats", rd_cnt, L);
      check_eq("sb_empty", exp_q.size(), 0);
      if (rdy_mode == 0) check_eq("throughput", last_pop_cyc - first_pop_cyc, L - 1);
    end
  endtask

  initial begin
    bit ab;
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    frame_len = 9'd8;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;

    run_frame(8,   100, 0, 32'h0000_0000, 0, ab);
    run_frame(16,  100, 1, 32'h1100_0000, 0, ab);
    run_frame(1,   100, 0, 32'h2200_0000, 0, ab);
    run_frame(256, 100, 0, 32'h3300_0000, 0, ab);
    run_frame(0,   100, 2, 32'h4400_0000, 0, ab);
    run_frame(300, 100, 0, 32'h4800_0000, 0, ab);
    run_frame(32,  50,  2, 32'h5500_0000, 0, ab);
    run_frame(16,  100, 0, 32'h6600_0000, 5, ab);
    check_eq("aborted", ab, 1);

    reset_n = 1'b0;
    @(posedge clock);
    #1;
    check_all_zero("mid_reset");
    reset_n = 1'b1;
    run_frame(8, 100, 0, 32'h7700_0000, 0, ab);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
